// File: rtl/rt_pkg.sv
// Shared constants for the reaction timer: FSM state codes, display glyphs and their segment patterns.
// The REACTION_BEST_EN build option is handled in the interface and core, not here.
package rt_pkg;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_COUNT      = 2'd1;
  localparam logic [1:0] ST_SHOW_SCORE = 2'd2;
  localparam logic [1:0] ST_SHOW_OVER  = 2'd3;

  localparam logic [3:0] BCD_NINE = 4'd9;

  // Digit glyphs share their BCD value, so nibbles 10..15 fall into undefined codes.
  typedef enum logic [4:0] {
    G_D0 = 5'd0, G_D1 = 5'd1, G_D2 = 5'd2, G_D3 = 5'd3, G_D4 = 5'd4,
    G_D5 = 5'd5, G_D6 = 5'd6, G_D7 = 5'd7, G_D8 = 5'd8, G_D9 = 5'd9,
    G_BLANK = 5'd16, G_DASH = 5'd17, G_O = 5'd18, G_V = 5'd19, G_E = 5'd20, G_R = 5'd21
  } glyph_t;

  function automatic glyph_t digit_glyph(input logic [3:0] nib);
    return glyph_t'({1'b0, nib});
  endfunction

  function automatic logic [3:0] clamp_bcd(input logic [3:0] nib);
    return (nib > BCD_NINE) ? BCD_NINE : nib;
  endfunction

  function automatic logic [7:0] glyph_seg(input glyph_t g);
    case (g)
      G_D0:    return 8'h3F;
      G_D1:    return 8'h06;
      G_D2:    return 8'h5B;
      G_D3:    return 8'h4F;
      G_D4:    return 8'h66;
      G_D5:    return 8'h6D;
      G_D6:    return 8'h7D;
      G_D7:    return 8'h07;
      G_D8:    return 8'h7F;
      G_D9:    return 8'h6F;
      G_O:     return 8'h3F;
      G_V:     return 8'h3E;
      G_E:     return 8'h79;
      G_R:     return 8'h50;
      G_BLANK: return 8'h00;
      G_DASH:  return 8'h40;
      default: return 8'h80;
    endcase
  endfunction

endpackage

// File: rtl/reaction_timer_core_if.sv
// Pad-side bundle of the reaction timer: button/preset in, segment and status out.
// best_o exists only when REACTION_BEST_EN is defined.
interface reaction_timer_core_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    btn_n;
  logic [3:0]              preset_msd;
  logic [7:0]              seg_o;
  logic                    busy_o;
  logic                    over_o;
  logic [4*NUM_DIGITS-1:0] score_o;
`ifdef REACTION_BEST_EN
  logic [4*NUM_DIGITS-1:0] best_o;

  modport master (output btn_n, preset_msd, input seg_o, busy_o, over_o, score_o, best_o);
  modport slave  (input btn_n, preset_msd, output seg_o, busy_o, over_o, score_o, best_o);
`else
  modport master (output btn_n, preset_msd, input seg_o, busy_o, over_o, score_o);
  modport slave  (input btn_n, preset_msd, output seg_o, busy_o, over_o, score_o);
`endif
endinterface

// File: rtl/reaction_timer_core_bcd_countdown.sv
// Parallel-load BCD down-counter; each digit borrows when every lower digit is zero.
// The owner must not assert dec while zero is high (the counter would wrap to all nines).
module bcd_countdown
  import rt_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  input  logic                    dec,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic                    zero
);
  localparam int VAL_W = 4 * NUM_DIGITS;

  logic [VAL_W-1:0] value_reg;
  logic [VAL_W-1:0] value_next;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    logic [3:0] digit;
    logic       borrow_in;

    assign digit = value_reg[4*gi +: 4];
    if (gi == 0) begin : g_lsd
      assign borrow_in = dec;
    end else begin : g_upper
      assign borrow_in = dec && (value_reg[4*gi-1:0] == '0);
    end
    assign value_next[4*gi +: 4] = !borrow_in ? digit :
                                   (digit == 4'd0) ? BCD_NINE : digit - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_reg <= '0;
    end else if (load) begin
      value_reg <= load_val;
    end else if (dec) begin
      value_reg <= value_next;
    end
  end

  assign value = value_reg;
  assign zero  = (value_reg == '0);
endmodule

// File: rtl/reaction_timer_core.sv
// Reaction-time game: button sync, countdown FSM, score capture and scrolling 7-segment display.
// Define REACTION_BEST_EN to keep a best score, expose best_o and append it to the score scroll.
module reaction_timer_core
  import rt_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int CLKS_PER_TICK = 1000,
  parameter int DISP_HOLD     = 10000000
) (
  input  logic                 clk,
  input  logic                 rst,
  reaction_timer_core_if.slave bus
);
  localparam int VAL_W  = 4 * NUM_DIGITS;
  localparam int TICK_W = $clog2(CLKS_PER_TICK + 1);
  localparam int HOLD_W = $clog2(DISP_HOLD + 1);
  localparam int CHAR_W = 5;
  localparam logic [TICK_W-1:0] TICK_RELOAD = TICK_W'(CLKS_PER_TICK - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(DISP_HOLD - 1);
  localparam logic [CHAR_W-1:0] OVER_LAST   = CHAR_W'(4);
`ifdef REACTION_BEST_EN
  localparam logic [CHAR_W-1:0] SCORE_LAST  = CHAR_W'(2 * NUM_DIGITS + 1);
`else
  localparam logic [CHAR_W-1:0] SCORE_LAST  = CHAR_W'(NUM_DIGITS);
`endif

  logic              btn_meta_reg, btn_sync_reg, btn_prev_reg;
  logic              press;
  logic [1:0]        state_reg, state_next;
  logic [TICK_W-1:0] tick_reg;
  logic [HOLD_W-1:0] hold_reg;
  logic [CHAR_W-1:0] char_reg, char_last;
  logic [7:0]        seg_reg;
  logic              over_reg;
  logic [VAL_W-1:0]  score_reg, load_val, cnt_value;
  logic              cnt_load, cnt_dec, cnt_zero, in_show;
  glyph_t            glyph;
`ifdef REACTION_BEST_EN
  logic [VAL_W-1:0]  best_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_meta_reg <= 1'b1;
      btn_sync_reg <= 1'b1;
      btn_prev_reg <= 1'b1;
    end else begin
      btn_meta_reg <= bus.btn_n;
      btn_sync_reg <= btn_meta_reg;
      btn_prev_reg <= btn_sync_reg;
    end
  end

  assign press    = btn_prev_reg && !btn_sync_reg;
  assign cnt_load = (state_reg == ST_IDLE) && press;
  assign cnt_dec  = (state_reg == ST_COUNT) && !press && (tick_reg == '0) && !cnt_zero;
  assign in_show  = (state_reg == ST_SHOW_SCORE) || (state_reg == ST_SHOW_OVER);
  assign char_last = (state_reg == ST_SHOW_OVER) ? OVER_LAST : SCORE_LAST;

  always_comb begin
    load_val = {NUM_DIGITS{BCD_NINE}};
    load_val[VAL_W-1 -: 4] = clamp_bcd(bus.preset_msd);
  end

  bcd_countdown #(.NUM_DIGITS(NUM_DIGITS)) u_countdown (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (load_val),
    .dec      (cnt_dec),
    .value    (cnt_value),
    .zero     (cnt_zero)
  );

  // A press during COUNT outranks expiry, so an all-zero score is possible.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (press) state_next = ST_COUNT;
      ST_COUNT: begin
        if (press) state_next = ST_SHOW_SCORE;
        else if ((tick_reg == '0) && cnt_zero) state_next = ST_SHOW_OVER;
      end
      default:  if (press) state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    glyph = G_BLANK;
    case (state_reg)
      ST_IDLE: glyph = G_DASH;
      ST_SHOW_OVER: begin
        case (char_reg)
          5'd1:    glyph = G_O;
          5'd2:    glyph = G_V;
          5'd3:    glyph = G_E;
          5'd4:    glyph = G_R;
          default: glyph = G_BLANK;
        endcase
      end
      ST_SHOW_SCORE: begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (char_reg == CHAR_W'(i + 1)) glyph = digit_glyph(score_reg[VAL_W-4-4*i +: 4]);
        end
`ifdef REACTION_BEST_EN
        if (char_reg == CHAR_W'(NUM_DIGITS + 1)) glyph = G_DASH;
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (char_reg == CHAR_W'(NUM_DIGITS + 2 + i)) glyph = digit_glyph(best_reg[VAL_W-4-4*i +: 4]);
        end
`endif
      end
      default: glyph = G_BLANK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      tick_reg  <= '0;
      hold_reg  <= '0;
      char_reg  <= '0;
      seg_reg   <= 8'h40;
      over_reg  <= 1'b0;
      score_reg <= '0;
    end else begin
      state_reg <= state_next;
      seg_reg   <= glyph_seg(glyph);
      over_reg  <= (state_next == ST_SHOW_OVER);
      if (cnt_load) tick_reg <= TICK_RELOAD;
      else if (state_reg == ST_COUNT) tick_reg <= (tick_reg == '0) ? TICK_RELOAD : tick_reg - TICK_W'(1);
      // Any state change restarts the scroll at the blank with a full hold period.
      if (state_next != state_reg) begin
        hold_reg <= '0;
        char_reg <= '0;
      end else if (in_show) begin
        if (hold_reg == HOLD_LAST) begin
          hold_reg <= '0;
          char_reg <= (char_reg == char_last) ? '0 : char_reg + CHAR_W'(1);
        end else begin
          hold_reg <= hold_reg + HOLD_W'(1);
        end
      end
      if ((state_reg == ST_COUNT) && press) score_reg <= cnt_value;
    end
  end

`ifdef REACTION_BEST_EN
  always_ff @(posedge clk) begin
    if (rst) best_reg <= '0;
    else if ((state_reg == ST_COUNT) && press && (cnt_value > best_reg)) best_reg <= cnt_value;
  end
  assign bus.best_o = best_reg;
`endif

  assign bus.seg_o   = seg_reg;
  assign bus.busy_o  = (state_reg == ST_COUNT);
  assign bus.over_o  = over_reg;
  assign bus.score_o = score_reg;
endmodule

// File: tb/tb_reaction_timer_core.sv
// Bench for reaction_timer_core with 3 digits, 4 clks/tick, 3 clks/character.
// Follows REACTION_BEST_EN: when defined, the best score is modelled and its scroll checked too.
module tb_reaction_timer_core;
  localparam int ND  = 3;
  localparam int CPT = 4;
  localparam int DH  = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reaction_timer_core_if #(.NUM_DIGITS(ND)) bus ();

  reaction_timer_core #(.NUM_DIGITS(ND), .CLKS_PER_TICK(CPT), .DISP_HOLD(DH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0]  preset;
    int          hold;
    int          wait_c;
    logic [11:0] exp_score;
  } vec_t;

  vec_t        vecs[8];
  logic [11:0] score_q[$];
  int          seg_q[$];
  logic [11:0] best_m;
  int          n_checks = 0;
  int          n_fail = 0;

  initial begin
    #1000000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "timeout");
  end

  function automatic int dig_seg(input logic [3:0] d);
    case (d)
      4'd0: return 'h3F;
      4'd1: return 'h06;
      4'd2: return 'h5B;
      4'd3: return 'h4F;
      4'd4: return 'h66;
      4'd5: return 'h6D;
      4'd6: return 'h7D;
      4'd7: return 'h07;
      4'd8: return 'h7F;
      4'd9: return 'h6F;
      default: return 'h80;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_score_seq(input logic [11:0] s);
    seg_q.push_back('h00);
    for (int i = 0; i < ND; i++) seg_q.push_back(dig_seg(s[4*(ND-1-i) +: 4]));
`ifdef REACTION_BEST_EN
    seg_q.push_back('h40);
    for (int i = 0; i < ND; i++) seg_q.push_back(dig_seg(best_m[4*(ND-1-i) +: 4]));
`endif
  endtask

  // Called at the negedge just after entry into a SHOW state.
  task automatic check_scroll();
    while (seg_q.size() > 0) begin
      int e;
      e = seg_q.pop_front();
      for (int j = 0; j < DH; j++) begin
        @(negedge clk);
        check("seg_scroll", bus.seg_o, e);
      end
    end
    @(negedge clk);
    check("seg_wrap", bus.seg_o, 'h00);
  endtask

  task automatic back_to_idle();
    @(posedge clk);
    #1 bus.btn_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("idle_busy", bus.busy_o, 0);
    check("idle_over", bus.over_o, 0);
    @(negedge clk);
    check("idle_seg", bus.seg_o, 'h40);
    bus.btn_n = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  // Start press is acted on 3 edges after btn_n falls (E0); second press at E(wait_c+3).
  task automatic run_game(input vec_t v);
    logic [11:0] exp_s;
    @(posedge clk);
    #1 bus.preset_msd = v.preset;
    bus.btn_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("busy_start", bus.busy_o, 1);
    repeat (v.hold) @(posedge clk);
    #1 check("busy_held", bus.busy_o, 1);
    bus.btn_n = 1'b1;
    repeat (v.wait_c - v.hold) @(posedge clk);
    #1 bus.btn_n = 1'b0;
    score_q.push_back(v.exp_score);
    if (v.exp_score > best_m) best_m = v.exp_score;
    push_score_seq(v.exp_score);
    repeat (3) @(posedge clk);
    @(negedge clk);
    exp_s = score_q.pop_front();
    check("busy_stop", bus.busy_o, 0);
    check("over_on_score", bus.over_o, 0);
    check("score", bus.score_o, exp_s);
`ifdef REACTION_BEST_EN
    check("best", bus.best_o, best_m);
`endif
    bus.btn_n = 1'b1;
    $display("game preset=%0h expected=%03h score_o=%03h", v.preset, exp_s, bus.score_o);
    check_scroll();
    back_to_idle();
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    bus.btn_n = 1'b1;
    bus.preset_msd = 4'd0;
    best_m = '0;
    vecs[0] = '{4'd1,  0,  46,  12'h187};
    vecs[1] = '{4'd1,  0,  194, 12'h150};
    vecs[2] = '{4'hC,  0,  1,   12'h999};
    vecs[3] = '{4'd2,  0,  2,   12'h298};
    vecs[4] = '{4'd5,  60, 70,  12'h581};
    vecs[5] = '{4'd1,  0,  402, 12'h098};
    vecs[6] = '{4'd0,  0,  397, 12'h000};
    vecs[7] = '{4'd9,  0,  10,  12'h996};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_seg", bus.seg_o, 'h40);
    check("rst_busy", bus.busy_o, 0);
    check("rst_over", bus.over_o, 0);
    check("rst_score", bus.score_o, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    foreach (vecs[k]) run_game(vecs[k]);

    // Loss: 099 needs 99 decrements plus one more tick to see zero at expiry.
    @(posedge clk);
    #1 bus.preset_msd = 4'd0;
    bus.btn_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("over_busy_start", bus.busy_o, 1);
    bus.btn_n = 1'b1;
    for (cyc = 1; cyc <= 600; cyc++) begin
      @(negedge clk);
      if (!bus.busy_o) break;
    end
    check("over_latency", cyc, 400);
    check("over_flag", bus.over_o, 1);
    $display("game preset=0 loss after %0d cycles over_o=%0d", cyc, bus.over_o);
    seg_q.push_back('h00);
    seg_q.push_back('h3F);
    seg_q.push_back('h3E);
    seg_q.push_back('h79);
    seg_q.push_back('h50);
    check_scroll();
    back_to_idle();

    // Reset held mid-COUNT.
    @(posedge clk);
    #1 bus.preset_msd = 4'd3;
    bus.btn_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus.btn_n = 1'b1;
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_seg", bus.seg_o, 'h40);
    check("midrst_busy", bus.busy_o, 0);
    check("midrst_over", bus.over_o, 0);
    check("midrst_score", bus.score_o, 0);
`ifdef REACTION_BEST_EN
    check("midrst_best", bus.best_o, 0);
`endif
    $display("reset mid-count: seg_o=%02h busy_o=%0d score_o=%03h", bus.seg_o, bus.busy_o, bus.score_o);
    best_m = '0;
    repeat (3) @(posedge clk);
    run_game(vecs[3]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
